// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//
// Two-digit packed-BCD modulo-MODULUS counter for one field of a clock
// (seconds/minutes with MODULUS=60, hours with MODULUS=24). Fields chain by
// feeding one instance's carry_o into the next instance's tick_i.
//
// A two-state mode machine (RUN/SET) decides which actions are honoured:
//   RUN : tick_i counts up, a wrap to 00 pulses carry_o.
//   SET : inc_i / dec_i adjust the value by one, ticks are dropped.
// load_i is honoured in both modes and has the highest priority.
// set_i toggles the mode. The action taken in the toggling cycle is
// evaluated against the mode that was current before the toggle.
//
// Parameters
//   MODULUS   count range 0..MODULUS-1, legal values 2..100
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   tick_i    count-enable pulse (RUN only)
//   set_i     mode toggle request pulse
//   inc_i     adjust +1 pulse (SET only)
//   dec_i     adjust -1 pulse (SET only)
//   load_i    parallel-load strobe (both modes)
//   load_val  packed BCD load value {tens, ones}
//   Q         packed BCD count {tens, ones}
//   carry_o   one-cycle pulse when a RUN tick wraps MODULUS-1 -> 0
//   load_err  one-cycle pulse when a load is rejected
//   set_mode  high while in SET; this is the mode machine's state bit
//
// Handshake: there is no back-pressure. Every strobe is a single-cycle
// request that is either acted on at the next rising edge or dropped; all
// outputs are registered and reflect the request one cycle later.
// -----------------------------------------------------------------------------
module bcd_mod_counter #(
    parameter int MODULUS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       set_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [7:0] load_val,
    output logic [7:0] Q,
    output logic       carry_o,
    output logic       load_err,
    output logic       set_mode
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } mode_e;

    // BCD digits of the terminal count MODULUS-1.
    localparam int         MAX_VAL  = MODULUS - 1;
    localparam logic [3:0] MAX_ONES = 4'(MAX_VAL % 10);
    localparam logic [3:0] MAX_TENS = 4'(MAX_VAL / 10);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mode_e      mode_q, mode_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       carry_q, carry_d;
    logic       load_err_q, load_err_d;

    // ------------------------------------------------------------------
    // Decodes of the current value
    // ------------------------------------------------------------------
    logic at_max;
    logic at_zero;

    // The digits always hold a legal value, so comparing digit by digit
    // is equivalent to comparing the binary value.
    assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    // ------------------------------------------------------------------
    // Load validation
    // ------------------------------------------------------------------
    logic [3:0] ld_ones;
    logic [3:0] ld_tens;
    logic       ld_digits_ok;
    logic       ld_range_ok;
    logic       ld_valid;

    assign ld_ones      = load_val[3:0];
    assign ld_tens      = load_val[7:4];
    assign ld_digits_ok = (ld_ones <= 4'd9) && (ld_tens <= 4'd9);
    // With both digits <= 9, value < MODULUS reduces to a lexicographic
    // compare of (tens, ones) against the terminal count digits.
    assign ld_range_ok  = (ld_tens < MAX_TENS) ||
                          ((ld_tens == MAX_TENS) && (ld_ones <= MAX_ONES));
    assign ld_valid     = ld_digits_ok && ld_range_ok;

    // ------------------------------------------------------------------
    // +1 and -1 candidates, shared by tick and adjust paths
    // ------------------------------------------------------------------
    logic [3:0] inc_ones, inc_tens;
    logic [3:0] dec_ones, dec_tens;

    always_comb begin
        inc_ones = ones_q;
        inc_tens = tens_q;
        // Terminal count is checked first so that e.g. 23 wraps to 00 for
        // MODULUS=24 instead of stepping to 24.
        if (at_max) begin
            inc_ones = 4'd0;
            inc_tens = 4'd0;
        end else if (ones_q == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = tens_q + 4'd1;
        end else begin
            inc_ones = ones_q + 4'd1;
        end
    end

    always_comb begin
        dec_ones = ones_q;
        dec_tens = tens_q;
        if (at_zero) begin
            dec_ones = MAX_ONES;
            dec_tens = MAX_TENS;
        end else if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
        end else begin
            dec_ones = ones_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: mode machine plus counter datapath
    // ------------------------------------------------------------------
    always_comb begin
        mode_d     = mode_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;

        // Mode toggle is independent of the data action in the same cycle.
        if (set_i) begin
            mode_d = (mode_q == ST_RUN) ? ST_SET : ST_RUN;
        end

        // Data action uses mode_q, i.e. the pre-toggle mode.
        if (load_i) begin
            if (ld_valid) begin
                ones_d = ld_ones;
                tens_d = ld_tens;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (mode_q == ST_SET) begin
            // Ticks arriving in SET fall through here and are dropped.
            if (inc_i && !dec_i) begin
                ones_d = inc_ones;
                tens_d = inc_tens;
            end else if (dec_i && !inc_i) begin
                ones_d = dec_ones;
                tens_d = dec_tens;
            end
        end else if (tick_i) begin
            ones_d  = inc_ones;
            tens_d  = inc_tens;
            carry_d = at_max;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= ST_RUN;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign Q        = {tens_q, ones_q};
    assign carry_o  = carry_q;
    assign load_err = load_err_q;
    assign set_mode = (mode_q == ST_SET);

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Two-digit BCD modulo-N counter that produces the packed BCD byte consumed by the clock's 7-segment digit decoder. Low nibble is the ones digit, high nibble the tens digit. One instance per clock field: seconds and minutes with N=60, hours with N=24. Fields are chained through `carry_o`. The block supports parallel load and user up/down adjustment, with a RUN/SET mode machine.

## Interface
- `MODULUS`, default 60: count range 0..MODULUS-1. Legal values are 2..100.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick_i` input 1: count-enable pulse, one cycle wide. In a chain, this is driven by the previous field's `carry_o`.
- `set_i` input 1: mode-toggle request pulse.
- `inc_i` input 1: adjust +1 pulse. Honoured only in SET.
- `dec_i` input 1: adjust −1 pulse. Honoured only in SET.
- `load_i` input 1: parallel-load strobe. Honoured in both modes.
- `load_val` input 8: packed BCD load value, {tens[7:4], ones[3:0]}.
- `Q` output 8: packed BCD count, {tens, ones}. Feeds the digit decoder directly.
- `carry_o` output 1: one-cycle pulse when a RUN tick wraps MODULUS-1 → 0.
- `load_err` output 1: one-cycle pulse when a load is rejected.
- `set_mode` output 1: 1 while in SET state. The display uses it for blinking.

## Operation
- The state is two 4-bit registers, `ones` and `tens`. Each always holds 0..9. The value tens*10+ones is always < MODULUS.
- Mode FSM:
  - States: RUN and SET. Reset state is RUN.
  - A `set_i` pulse toggles RUN↔SET. Nothing else changes state.
- Priority within one cycle, highest first:
  1. `load_i`
  2. `inc_i`/`dec_i` (SET only)
  3. `tick_i` (RUN only)
- A `set_i` toggle coexists with any of the above. The action in that cycle is evaluated against the pre-toggle state.
- Load:
  - Valid when both nibbles ≤ 9 and value < MODULUS. A valid load sets Q = `load_val` on the next edge.
  - An invalid load leaves Q unchanged and pulses `load_err` for one cycle.
  - A load never produces `carry_o`.
- Tick (RUN, no load):
  - If ones < 9 and value ≠ MODULUS-1: ones += 1.
  - Else if ones = 9: ones = 0, tens += 1.
  - If value = MODULUS-1: Q = 0x00 and `carry_o` = 1 for one cycle.
  - The MODULUS-1 check takes precedence, so for MODULUS=24, 23 → 00 and not 24.
- Ticks in SET are dropped. They are not queued.
- Adjust (SET, no load):
  - `inc_i` alone: same +1 rule as tick, wrapping MODULUS-1 → 0, but no `carry_o`.
  - `dec_i` alone: −1. Ones 0 → 9 with tens −1. Value 0 wraps to MODULUS-1, with no borrow output.
  - `inc_i` and `dec_i` together: no change.
  - Adjust pulses in RUN are ignored.
- Reset values, asynchronous on `rst_n` low: Q = 0x00, `carry_o` = 0, `load_err` = 0, `set_mode` = 0 (RUN).
- `rst_n` asserted mid-operation clears everything immediately, without waiting for a clock edge. Operation resumes on the first rising edge after deassertion.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency is one cycle: an input sampled at edge k is reflected in Q, `carry_o`, `load_err` and `set_mode` after edge k.
- `carry_o` is high in exactly the cycle in which Q first shows 0x00 after a wrap.
- Chained fields:
  - The downstream field samples `carry_o` as its `tick_i` and updates one cycle after the upstream wrap.
  - The ripple delay is one cycle per stage. This is accepted.
- Continuous `tick_i` high counts once per cycle. The BCD sequence is 58, 59, 00, 01 for MODULUS=60, with `carry_o` high only on 00.
- `set_i` held high toggles the mode every cycle. Debouncing and edge detection are upstream.

## Test plan
- Reset: assert `rst_n`=0 mid-count at Q=0x37, asynchronously between edges → Q=0x00, `set_mode`=0 and `carry_o`=0 immediately, before the next edge.
- Full wrap, MODULUS=60: 60 consecutive ticks from 0x00 → Q passes 0x09→0x10 and 0x59→0x00. `carry_o` pulses exactly once, on the 60th tick. Q never shows 0x0A–0x0F.
- Hours, MODULUS=24: load 0x23, then tick → Q=0x00 and `carry_o`=1. Load 0x24 → Q stays 0x00 and `load_err`=1 for one cycle. Load 0x1A → rejected the same way.
- SET adjust: `set_i` pulse, then `dec_i` at Q=0x00 → Q=0x59 with no `carry_o`. `inc_i` → 0x00. `inc_i`+`dec_i` together → no change. `tick_i` in SET → no change. A second `set_i` → RUN, and ticks resume.
- Priority: same cycle with `load_i`(0x45), `tick_i` and `set_i` in RUN → Q=0x45 and `set_mode`=1 next cycle, no increment.
- Chain: three instances (60/60/24) tick-chained from 23:59:59, one tick → seconds 00 at +1 cycle, minutes 00 at +2, hours 00 at +3. The hours instance pulses `carry_o` at +3.
